// File: rtl/seg_pkg.sv
// Shared constants for the seg_scan_ctrl display scanner: FSM encodings,
// blank segment pattern and the largest valid BCD digit.
package seg_pkg;

    localparam logic [0:0] ST_DEAD = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    function automatic logic is_bcd(input logic [3:0] nib);
        return nib <= BCD_MAX;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick.sv
// scan_tick_gen: slot counter 0..DIV-1 for the display scanner.
// Count 0 is the dead-time cycle of a slot; count DIV-1 is its last lit cycle.
module scan_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic dead_start,
    output logic slot_end
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign dead_start = (cnt == '0);
    assign slot_end   = (cnt == LAST_CNT);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scanner sharing one external BCD-to-7-segment
// decoder among NDIG digits. Optional macro SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] din,
    output logic              applied,
    output logic [3:0]        bcd_code,
    input  logic [6:0]        seg_in,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an
);

    localparam int IW = $clog2(NDIG);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    logic              dead_start;
    logic              slot_end;
    logic [0:0]        state;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] disp;
    logic [4*NDIG-1:0] pend;
    logic              pend_v;
    logic              lz_blank;
    logic              frame_end;
    logic [3:0]        cur_nib;
    logic              cur_lz;

    scan_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .dead_start(dead_start),
        .slot_end  (slot_end)
    );

    assign frame_end = (state == ST_SHOW) && slot_end && (idx == LAST_IDX);

    always_comb begin
        cur_nib = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (IW'(k) == idx) begin
                cur_nib = disp[4*k +: 4];
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // A digit is blanked when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        cur_lz      = 1'b0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            higher_zero = higher_zero && (disp[4*k +: 4] == 4'd0);
            if ((IW'(k) == idx) && (k != 0)) begin
                cur_lz = higher_zero;
            end
        end
    end
`else
    assign cur_lz = 1'b0;
`endif

    // Scan FSM; anode, code and blank flag are registered on entry to SHOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_DEAD;
            idx      <= '0;
            an       <= '1;
            bcd_code <= '0;
            lz_blank <= 1'b0;
        end else begin
            case (state)
                ST_DEAD: begin
                    if (dead_start) begin
                        state    <= ST_SHOW;
                        an       <= ~(NDIG'(1) << idx);
                        bcd_code <= cur_nib;
                        lz_blank <= cur_lz;
                    end
                end
                ST_SHOW: begin
                    if (slot_end) begin
                        state <= ST_DEAD;
                        an    <= '1;
                        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_DEAD;
                    an    <= '1;
                end
            endcase
        end
    end

    // A load in the boundary cycle always lands in pend for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp    <= '0;
            pend    <= '0;
            pend_v  <= 1'b0;
            applied <= 1'b0;
        end else begin
            applied <= frame_end && pend_v;
            if (frame_end && pend_v) begin
                disp <= pend;
            end
            if (load) begin
                pend   <= din;
                pend_v <= 1'b1;
            end else if (frame_end) begin
                pend_v <= 1'b0;
            end
        end
    end

    assign seg = ((state == ST_DEAD) || !is_bcd(bcd_code) || lz_blank) ? SEG_BLANK : seg_in;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=4, DIV=4) with a bench-side decoder
// and a scoreboard of expected {apply cycle, display word} entries.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int FRAME = NDIG * DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] din   = '0;
    logic        applied;
    logic [3:0]  bcd_code;
    logic [6:0]  seg_in;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [47:0] exp_q[$];
    logic [47:0] mon_e;
    logic        busy = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NDIG(NDIG),
        .DIV (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .din     (din),
        .applied (applied),
        .bcd_code(bcd_code),
        .seg_in  (seg_in),
        .seg     (seg),
        .an      (an)
    );

    // Bench decoder (gfedcba); invalid codes return all-on so forced blanking is visible.
    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h7F;
        endcase
    endfunction

    assign seg_in = dec(bcd_code);

    function automatic logic [6:0] exp_seg(input logic [15:0] word, input int k);
        logic [3:0] nib;
        nib = word[4*k +: 4];
        if (nib > 4'd9) return 7'h00;
`ifdef SEG_LZ_BLANK_EN
        if (k != 0 && (word >> (4 * k)) == 16'h0) return 7'h00;
`endif
        return dec(nib);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Checks one whole frame starting at its first dead cycle (current negedge).
    task automatic check_frame(input logic [15:0] word, input string pfx);
        int k;
        int j;
        for (int s = 0; s < FRAME; s++) begin
            if (s > 0) @(negedge clk);
            if (!rst_n) return;
            k = s / DIV;
            j = s % DIV;
            if (j == 0) begin
                check($sformatf("%s_dead_an_d%0d", pfx, k), 32'(an), 32'hF);
                check($sformatf("%s_dead_seg_d%0d", pfx, k), 32'(seg), 32'h0);
            end else begin
                check($sformatf("%s_an_d%0d", pfx, k), 32'(an), 32'(~(4'b0001 << k) & 4'hF));
                check($sformatf("%s_code_d%0d", pfx, k), 32'(bcd_code), 32'(word[4*k +: 4]));
                check($sformatf("%s_seg_d%0d", pfx, k), 32'(seg), 32'(exp_seg(word, k)));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && applied) begin
            busy = 1'b1;
            check("applied_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("applied_cycle", 32'(cyc), mon_e[47:16]);
                check_frame(mon_e[15:0], "frm");
            end
            busy = 1'b0;
        end
    end

    // Drives a one-cycle load at the current negedge; the apply cycle is the
    // next frame start, or the one after if the load sits in the boundary cycle.
    task automatic do_load(input logic [15:0] v, input bit expect_apply);
        int c;
        int ap;
        c = cyc;
        ap = (c % FRAME == FRAME - 1) ? (c / FRAME + 2) * FRAME : (c / FRAME + 1) * FRAME;
        load = 1'b1;
        din  = v;
        if (expect_apply) exp_q.push_back({32'(ap), v});
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (cyc % FRAME == p) return;
        end
        check("wait_pos_timeout", 32'(cyc % FRAME), 32'(p));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 8 * FRAME; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) return;
        end
        check("idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_code", 32'(bcd_code), 32'h0);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_applied", 32'(applied), 32'h0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_frame(16'h0000, "boot");

        wait_pos(5);
        do_load(16'h1234, 1'b1);
        wait_idle();

        wait_pos(3);
        do_load(16'h1111, 1'b0);
        wait_pos(8);
        do_load(16'h5678, 1'b1);
        wait_idle();

        wait_pos(2);
        do_load(16'h00A3, 1'b1);
        wait_idle();

        // Load in the boundary cycle while another value is pending.
        wait_pos(4);
        do_load(16'h4321, 1'b1);
        wait_pos(FRAME - 1);
        do_load(16'h9087, 1'b1);
        wait_idle();

        // Load in the boundary cycle with nothing pending.
        wait_pos(FRAME - 1);
        do_load(16'h2468, 1'b1);
        wait_idle();

        // Reset during SHOW of digit 2 with a value pending.
        wait_pos(2);
        do_load(16'h7777, 1'b0);
        wait_pos(2 * DIV + 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h0);
        check("midrst_code", 32'(bcd_code), 32'h0);
        check("midrst_applied", 32'(applied), 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_frame(16'h0000, "rerun");
        repeat (3 * FRAME) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
